// File: rtl/ram_bist_ctrl.sv
// rtl/ram_bist_ctrl.sv - write/read-back BIST initiator for a simple dual-port block RAM
// Optional second inverted write/read pass enabled by defining RAM_BIST_MARCH_EN.
module ram_bist_ctrl #(
    parameter int                ADDR_W = 4,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] SEED   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ADDR_W+1:0] fail_cnt,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_w_addr,
    output logic [DATA_W-1:0] ram_w_data,
    output logic              ram_r_en,
    output logic [ADDR_W-1:0] ram_r_addr,
    input  logic [DATA_W-1:0] ram_r_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
`ifdef RAM_BIST_MARCH_EN
        , S_WRITE_INV,
        S_READ_INV
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) ^ SEED;
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic [ADDR_W+1:0]   fail_cnt_q, fail_cnt_d;
    logic                w_en_q, w_en_d;
    logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic                r_en_q, r_en_d;
    logic [ADDR_W-1:0]   r_addr_q, r_addr_d;
    logic                cmp_vld_q;
    logic [ADDR_W-1:0]   cmp_addr_q;
    logic [DATA_W-1:0]   cmp_exp;
    logic                miss;
    logic                inv_d;

`ifdef RAM_BIST_MARCH_EN
    logic cmp_inv_q;
    assign cmp_exp = pattern(cmp_addr_q) ^ {DATA_W{cmp_inv_q}};
`else
    assign cmp_exp = pattern(cmp_addr_q);
`endif

    assign miss = cmp_vld_q && (ram_r_data != cmp_exp);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_cnt_d  = fail_cnt_q;
        inv_d       = 1'b0;

        if (miss) begin
            fail_cnt_d = fail_cnt_q + (ADDR_W+2)'(1);
            if (fail_cnt_q == '0) begin
                fail_addr_d = cmp_addr_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WRITE;
                    cnt_d       = '0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_cnt_d  = '0;
                end
            end
            S_WRITE: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end
            end
            S_READ: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST) begin
`ifdef RAM_BIST_MARCH_EN
                    state_d = S_WRITE_INV;
`else
                    state_d = S_DRAIN;
`endif
                    cnt_d   = '0;
                end
            end
`ifdef RAM_BIST_MARCH_EN
            S_WRITE_INV: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST) begin
                    state_d = S_READ_INV;
                    cnt_d   = '0;
                end
            end
            S_READ_INV: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
`endif
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Registered outputs are decoded from the next state so they line up with state_q.
        if (state_d == S_DONE) begin
            pass_d = (fail_cnt_d == '0);
        end

`ifdef RAM_BIST_MARCH_EN
        inv_d  = (state_d == S_WRITE_INV) || (state_d == S_READ_INV);
        w_en_d = (state_d == S_WRITE) || (state_d == S_WRITE_INV);
        r_en_d = (state_d == S_READ) || (state_d == S_READ_INV);
`else
        w_en_d = (state_d == S_WRITE);
        r_en_d = (state_d == S_READ);
`endif
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        w_addr_d = w_en_d ? cnt_d : '0;
        w_data_d = w_en_d ? (pattern(cnt_d) ^ {DATA_W{inv_d}}) : '0;
        r_addr_d = r_en_d ? cnt_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_cnt_q  <= '0;
            w_en_q      <= 1'b0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
            r_en_q      <= 1'b0;
            r_addr_q    <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_addr_q  <= '0;
`ifdef RAM_BIST_MARCH_EN
            cmp_inv_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_cnt_q  <= fail_cnt_d;
            w_en_q      <= w_en_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            r_en_q      <= r_en_d;
            r_addr_q    <= r_addr_d;
            cmp_vld_q   <= r_en_q;
            cmp_addr_q  <= r_addr_q;
`ifdef RAM_BIST_MARCH_EN
            cmp_inv_q   <= (state_q == S_READ_INV);
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_addr  = fail_addr_q;
    assign fail_cnt   = fail_cnt_q;
    assign ram_w_en   = w_en_q;
    assign ram_w_addr = w_addr_q;
    assign ram_w_data = w_data_q;
    assign ram_r_en   = r_en_q;
    assign ram_r_addr = r_addr_q;

endmodule
